// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_MAX_LEN = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

endpackage

// File: rtl/seq_match_core.sv
// History shift register, saturating fresh-bit counter and masked pattern compare.
module seq_match_core #(
    parameter int MAX_LEN = 8,
    parameter int LW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift,
    input  logic               data,
    input  logic               overlap,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      len,
    output logic               match
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_new;
    logic [MAX_LEN-1:0] mask;
    logic [LW-1:0]      bcnt_q;
    logic [LW:0]        bcnt_inc;

    assign hist_new = {hist_q[MAX_LEN-2:0], data};
    assign bcnt_inc = {1'b0, bcnt_q} + (LW+1)'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // bcnt_inc counts the bit being sampled now, so a match needs len bits including it
    assign match = shift && (bcnt_inc >= {1'b0, len}) &&
                   ((hist_new & mask) == (pattern & mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            bcnt_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            bcnt_q <= '0;
        end else if (shift) begin
            hist_q <= hist_new;
            if (match && !overlap) begin
                bcnt_q <= '0;
            end else if (bcnt_q != LW'(MAX_LEN)) begin
                bcnt_q <= bcnt_q + LW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence-detector controller: config capture, IDLE/RUN/DONE FSM, match counting.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_cfg_valid,
    output logic                         o_cfg_ready,
    input  logic [MAX_LEN-1:0]           i_cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] i_cfg_len,
    input  logic                         i_cfg_overlap,
    input  logic [CNT_W-1:0]             i_cfg_target,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_valid,
    input  logic                         i_data,
    output logic                         o_detect,
    output logic [CNT_W-1:0]             o_match_count,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int LW = $clog2(MAX_LEN + 1);

    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
        if (len == '0) return LW'(1);
        if (len > LW'(MAX_LEN)) return LW'(MAX_LEN);
        return len;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               detect_p1;
    logic               cfg_take;
    logic               clr;
    logic               shift;
    logic               hit;

    // Abort outranks both a pending start and a match sampled in the same cycle
    assign shift    = (state_q == RUN) && i_valid && !i_abort;
    assign clr      = i_start && ((state_q == IDLE) || ((state_q == DONE) && !i_abort));
    assign cfg_take = (state_q == IDLE) && i_cfg_valid;
    assign cnt_inc  = sat_inc(cnt_q);

    seq_match_core #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_core (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .clr     (clr),
        .shift   (shift),
        .data    (i_data),
        .overlap (ovl_q),
        .pattern (pat_q),
        .len     (eff_len(len_q)),
        .match   (hit)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_cfg_ready = 1'b0;
        case (state_q)
            IDLE: begin
                o_cfg_ready = 1'b1;
                if (i_start) state_d = RUN;
            end
            RUN: begin
                if (i_abort) state_d = IDLE;
                else if (hit && (tgt_q != '0) && (cnt_inc == tgt_q)) state_d = DONE;
            end
            DONE: begin
                if (i_abort)      state_d = IDLE;
                else if (i_start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: registered detect pulse and match counter
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            detect_p1 <= 1'b0;
        end else begin
            detect_p1 <= hit;
            if (cfg_take) begin
                pat_q <= i_cfg_pattern;
                len_q <= i_cfg_len;
                ovl_q <= i_cfg_overlap;
                tgt_q <= i_cfg_target;
            end
            if (clr)      cnt_q <= '0;
            else if (hit) cnt_q <= cnt_inc;
        end
    end

    assign o_detect      = detect_p1;
    assign o_match_count = cnt_q;
    assign o_busy        = (state_q == RUN);
    assign o_done        = (state_q == DONE);

endmodule
